// File: rtl/shared_counters_pkg.sv
// rtl/shared_counters_pkg.sv - shared types and width helpers for shared_counter_pool
package shared_counters_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_INC   = 3'd1,
    OP_ALLOC = 3'd2,
    OP_FREE  = 3'd3,
    OP_LOAD  = 3'd4,
    OP_READ  = 3'd5
  } cmd_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int size_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int N_DEFAULT      = 10;
  localparam int ID_W_DEFAULT   = id_width(N_DEFAULT);
  localparam int SIZE_W_DEFAULT = size_width(N_DEFAULT);

endpackage

// File: rtl/shared_counter_pool_if.sv
// rtl/shared_counter_pool_if.sv - command, response and read-stream bundle of shared_counter_pool
interface shared_counter_pool_if
  import shared_counters_pkg::*;
#(
  parameter int N       = 10,
  parameter int G       = 4,
  parameter int MAX_LEN = N
);
  localparam int ID_W   = id_width(N);
  localparam int SIZE_W = size_width(MAX_LEN);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ID_W-1:0]   cmd_id;
  logic [SIZE_W-1:0] cmd_size;
  logic [G-1:0]      cmd_data;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_err;
  logic              rd_valid;
  logic              rd_ready;
  logic [G-1:0]      rd_data;
  logic              rd_last;

  modport master (
    output cmd_valid, cmd_op, cmd_id, cmd_size, cmd_data, rd_ready,
    input  cmd_ready, rsp_valid, rsp_id, rsp_err, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_id, cmd_size, cmd_data, rd_ready,
    output cmd_ready, rsp_valid, rsp_id, rsp_err, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/sc_first_fit.sv
// rtl/sc_first_fit.sv - lowest base with size contiguous free slices
module sc_first_fit
  import shared_counters_pkg::*;
#(
  parameter int N       = 10,
  parameter int MAX_LEN = N,
  localparam int ID_W   = id_width(N),
  localparam int SIZE_W = size_width(MAX_LEN)
) (
  input  logic [N-1:0]      used,
  input  logic [SIZE_W-1:0] size,
  output logic              found,
  output logic [ID_W-1:0]   base
);

  // Scan high to low so the last hit written is the lowest base.
  always_comb begin : search
    logic fit;
    fit   = 1'b0;
    found = 1'b0;
    base  = '0;
    for (int b = N - 1; b >= 0; b--) begin
      fit = (size != '0) && (b + int'(size) <= N);
      for (int j = 0; j < N; j++) begin
        if (j >= b && j < b + int'(size) && used[j]) fit = 1'b0;
      end
      if (fit) begin
        found = 1'b1;
        base  = ID_W'(b);
      end
    end
  end

endmodule

// File: rtl/shared_counter_pool.sv
// rtl/shared_counter_pool.sv - pool of G-bit slices grouped into variable-length counters
// Define SHARED_COUNTER_SATURATE_EN for saturating counters; default wraps modulo 2^(len*G).
module shared_counter_pool
  import shared_counters_pkg::*;
#(
  parameter int N       = 10,
  parameter int G       = 4,
  parameter int MAX_LEN = N
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_counter_pool_if.slave bus,
  input  logic [N-1:0]         inc_req,
  output logic [N-1:0]         ovf,
  output logic [N*G-1:0]       cnt_flat
);
  localparam int ID_W   = id_width(N);
  localparam int SIZE_W = size_width(MAX_LEN);
  localparam logic [G-1:0] ONES = '1;

  logic [G-1:0]         data_q [N];
  logic [G-1:0]         data_n [N];
  logic [G-1:0]         sum    [N];
  logic [SIZE_W-1:0]    len_q  [N];
  logic [SIZE_W-1:0]    len_n  [N];
  logic [ID_W-1:0]      base_of[N];
  logic [N-1:0]         used_q, used_n, head_q, head_n;
  logic [N-1:0]         inc_en, wrap, sat_hold, ovf_n;
  rd_state_e            state_q, state_n;
  logic [MAX_LEN*G-1:0] snap_q, snap_n, snap_fill;
  logic [SIZE_W-1:0]    beat_q, beat_n, rd_len_q, rd_len_n, id_len;
  logic                 accept, id_ok, size_ok, fit_found;
  logic [ID_W-1:0]      fit_base, rsp_id_n;
  logic                 rsp_valid_n, rsp_err_n;
  logic                 do_inc, do_free, do_load, do_read, do_alloc;

  sc_first_fit #(.N(N), .MAX_LEN(MAX_LEN)) u_first_fit (
    .used  (used_q),
    .size  (bus.cmd_size),
    .found (fit_found),
    .base  (fit_base)
  );

  assign accept  = bus.cmd_valid && bus.cmd_ready;
  assign size_ok = (bus.cmd_size != '0) && (int'(bus.cmd_size) <= MAX_LEN);

  always_comb begin : decode
    id_ok  = 1'b0;
    id_len = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.cmd_id == ID_W'(i)) begin
        id_ok  = head_q[i];
        id_len = len_q[i];
      end
    end
    do_inc      = accept && (bus.cmd_op == OP_INC)  && id_ok;
    do_free     = accept && (bus.cmd_op == OP_FREE) && id_ok;
    do_load     = accept && (bus.cmd_op == OP_LOAD) && id_ok;
    do_read     = accept && (bus.cmd_op == OP_READ) && id_ok;
    do_alloc    = accept && (bus.cmd_op == OP_ALLOC) && size_ok && fit_found;
    rsp_valid_n = accept && (bus.cmd_op != OP_NOP);
    rsp_id_n    = bus.cmd_id;
    rsp_err_n   = 1'b0;
    case (bus.cmd_op)
      OP_NOP:   rsp_err_n = 1'b0;
      OP_ALLOC: begin
        rsp_err_n = !(size_ok && fit_found);
        rsp_id_n  = rsp_err_n ? '0 : fit_base;
      end
      OP_INC, OP_FREE, OP_LOAD, OP_READ: rsp_err_n = !id_ok;
      default:  rsp_err_n = 1'b1;
    endcase
  end

  // Carry enters at each head and ripples through the continuation slices of that counter.
  always_comb begin : chain
    logic [ID_W-1:0] cur;
    logic            c;
    cur = '0;
    c   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (head_q[i]) cur = ID_W'(i);
      base_of[i] = cur;
      inc_en[i]  = head_q[i]
                 && (inc_req[i] || (do_inc && bus.cmd_id == ID_W'(i)))
                 && !((do_free || do_load) && bus.cmd_id == ID_W'(i));
      if (head_q[i])       c = inc_en[i];
      else if (!used_q[i]) c = 1'b0;
      sum[i]  = data_q[i] + G'(c);
      c       = c && (data_q[i] == ONES);
      wrap[i] = c && used_q[i]
              && ((i == N - 1) || !used_q[(i + 1) % N] || head_q[(i + 1) % N]);
    end
  end

  always_comb begin : wrap_map
    ovf_n = '0;
    for (int b = 0; b < N; b++) begin
      for (int i = 0; i < N; i++) begin
        if (wrap[i] && base_of[i] == ID_W'(b)) ovf_n[b] = 1'b1;
      end
    end
`ifdef SHARED_COUNTER_SATURATE_EN
    sat_hold = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (wrap[j] && base_of[j] == base_of[i]) sat_hold[i] = 1'b1;
      end
    end
`else
    sat_hold = '0;
`endif
  end

  // FREE/LOAD override the increment result of the addressed counter.
  always_comb begin : next_state
    data_n = data_q;
    len_n  = len_q;
    used_n = used_q;
    head_n = head_q;
    for (int i = 0; i < N; i++) begin
      if (used_q[i] && !sat_hold[i]) data_n[i] = sum[i];
      if ((do_free || do_load) && used_q[i] && base_of[i] == bus.cmd_id) begin
        data_n[i] = (do_load && bus.cmd_id == ID_W'(i)) ? bus.cmd_data : '0;
        if (do_free) begin
          used_n[i] = 1'b0;
          head_n[i] = 1'b0;
          len_n[i]  = '0;
        end
      end
      if (do_alloc && i >= int'(fit_base) && i < int'(fit_base) + int'(bus.cmd_size)) begin
        used_n[i] = 1'b1;
        head_n[i] = (i == int'(fit_base));
        data_n[i] = '0;
        len_n[i]  = (i == int'(fit_base)) ? bus.cmd_size : '0;
      end
    end
  end

  always_comb begin : snapshot
    snap_fill = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      for (int j = 0; j < N; j++) begin
        if (j == int'(bus.cmd_id) + k && k < int'(id_len)) snap_fill[k*G +: G] = data_q[j];
      end
    end
  end

  always_comb begin : read_fsm
    state_n  = state_q;
    beat_n   = beat_q;
    rd_len_n = rd_len_q;
    snap_n   = snap_q;
    case (state_q)
      IDLE: if (do_read) begin
        state_n  = READ;
        beat_n   = '0;
        rd_len_n = id_len;
        snap_n   = snap_fill;
      end
      READ: if (bus.rd_ready) begin
        if (beat_q == rd_len_q - 1'b1) state_n = IDLE;
        else                           beat_n  = beat_q + 1'b1;
        snap_n = snap_q >> G;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rd_valid  = (state_q == READ);
  assign bus.rd_data   = snap_q[G-1:0];
  assign bus.rd_last   = (state_q == READ) && (beat_q == rd_len_q - 1'b1);

  for (genvar gi = 0; gi < N; gi++) begin : g_flat
    assign cnt_flat[gi*G +: G] = data_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        data_q[i] <= '0;
        len_q[i]  <= '0;
      end
      used_q        <= '0;
      head_q        <= '0;
      state_q       <= IDLE;
      snap_q        <= '0;
      beat_q        <= '0;
      rd_len_q      <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_id    <= '0;
      ovf           <= '0;
    end else begin
      data_q        <= data_n;
      len_q         <= len_n;
      used_q        <= used_n;
      head_q        <= head_n;
      state_q       <= state_n;
      snap_q        <= snap_n;
      beat_q        <= beat_n;
      rd_len_q      <= rd_len_n;
      bus.rsp_valid <= rsp_valid_n;
      bus.rsp_err   <= rsp_err_n;
      bus.rsp_id    <= rsp_id_n;
      ovf           <= ovf_n;
    end
  end

endmodule

// File: tb/tb_shared_counter_pool.sv
// tb/tb_shared_counter_pool.sv - scoreboard bench for shared_counter_pool
module tb_shared_counter_pool;
  import shared_counters_pkg::*;

  localparam int N = 10;
  localparam int G = 4;
  localparam int MAX_LEN = 10;

  typedef struct packed {
    logic [3:0] id;
    logic       err;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     inc_req;
  logic [N-1:0]     ovf;
  logic [N*G-1:0]   cnt_flat;

  int   checks = 0;
  int   errors = 0;
  int   ovf0_cnt = 0;
  int   ovf_other = 0;
  int   incs;
  int   prev_ovf;
  bit   done;
  rsp_t rsp_q[$];
  rsp_t exp_rsp;
  logic [4:0] beat_q[$];
  logic [4:0] exp_beat;

  shared_counter_pool_if #(.N(N), .G(G), .MAX_LEN(MAX_LEN)) bus ();

  shared_counter_pool #(.N(N), .G(G), .MAX_LEN(MAX_LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .inc_req  (inc_req),
    .ovf      (ovf),
    .cnt_flat (cnt_flat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [3:0] id, input logic [3:0] size,
                        input logic [3:0] data, input bit exp_valid, input logic [3:0] exp_id,
                        input logic exp_err);
    int n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("cmd_ready_timeout", {31'd0, bus.cmd_ready}, 32'd1);
    if (exp_valid) rsp_q.push_back('{id: exp_id, err: exp_err});
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_id    = id;
    bus.cmd_size  = size;
    bus.cmd_data  = data;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or a read beat.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.rsp_valid) begin
          if (rsp_q.size() == 0) begin
            check("rsp_unexpected", {31'd0, bus.rsp_valid}, 32'd0);
          end else begin
            exp_rsp = rsp_q.pop_front();
            check("rsp_id", {28'd0, bus.rsp_id}, {28'd0, exp_rsp.id});
            check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_rsp.err});
          end
        end
        if (bus.rd_valid && bus.rd_ready) begin
          if (beat_q.size() == 0) begin
            check("beat_unexpected", {31'd0, bus.rd_valid}, 32'd0);
          end else begin
            exp_beat = beat_q.pop_front();
            check("rd_data", {28'd0, bus.rd_data}, {28'd0, exp_beat[3:0]});
            check("rd_last", {31'd0, bus.rd_last}, {31'd0, exp_beat[4]});
          end
        end
        if (ovf[0]) ovf0_cnt++;
        if (ovf[N-1:1] != '0) ovf_other++;
      end
    end
  end

  initial begin
    rst          = 1'b1;
    inc_req      = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op   = OP_NOP;
    bus.cmd_id   = '0;
    bus.cmd_size = '0;
    bus.cmd_data = '0;
    bus.rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("reset_rsp_id", {28'd0, bus.rsp_id}, 32'd0);
    check("reset_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("reset_rd_last", {31'd0, bus.rd_last}, 32'd0);
    check("reset_ovf", {22'd0, ovf}, 32'd0);
    check("reset_cnt_lo", cnt_flat[31:0], 32'd0);
    check("reset_cnt_hi", {24'd0, cnt_flat[39:32]}, 32'd0);

    // First-fit allocation until the pool is full.
    do_cmd(OP_ALLOC, 4'd0, 4'd3, 4'd0, 1, 4'd0, 1'b0);
    do_cmd(OP_ALLOC, 4'd0, 4'd1, 4'd0, 1, 4'd3, 1'b0);
    do_cmd(OP_ALLOC, 4'd0, 4'd4, 4'd0, 1, 4'd4, 1'b0);
    do_cmd(OP_ALLOC, 4'd0, 4'd2, 4'd0, 1, 4'd8, 1'b0);
    do_cmd(OP_ALLOC, 4'd0, 4'd1, 4'd0, 1, 4'd0, 1'b1);

    do_cmd(OP_FREE,  4'd3, 4'd0, 4'd0, 1, 4'd3, 1'b0);
    do_cmd(OP_FREE,  4'd4, 4'd0, 4'd0, 1, 4'd4, 1'b0);
    do_cmd(OP_ALLOC, 4'd0, 4'd5, 4'd0, 1, 4'd3, 1'b0);
    do_cmd(OP_LOAD,  4'd3, 4'd0, 4'd7, 1, 4'd3, 1'b0);
    do_cmd(OP_FREE,  4'd5, 4'd0, 4'd0, 1, 4'd5, 1'b1);
    do_cmd(3'd6,     4'd2, 4'd0, 4'd0, 1, 4'd2, 1'b1);
    do_cmd(OP_NOP,   4'd1, 4'd0, 4'd0, 0, 4'd0, 1'b0);
    @(negedge clk);
    check("slices_after_bad_free", {12'd0, cnt_flat[31:12]}, 32'h00007);

    // 4096 strobes on the len-3 counter at base 0.
    @(posedge clk);
    #1 inc_req[0] = 1'b1;
    repeat (4096) @(posedge clk);
    #1 inc_req[0] = 1'b0;
    repeat (3) @(negedge clk);
`ifdef SHARED_COUNTER_SATURATE_EN
    check("cnt0_after_4096", {20'd0, cnt_flat[11:0]}, 32'h0FFF);
`else
    check("cnt0_after_4096", {20'd0, cnt_flat[11:0]}, 32'h0000);
`endif
    check("ovf0_pulses", ovf0_cnt, 1);
    check("ovf_other_pulses", ovf_other, 0);

    do_cmd(OP_LOAD, 4'd0, 4'd0, 4'hF, 1, 4'd0, 1'b0);
    @(negedge clk);
    check("cnt0_load", {20'd0, cnt_flat[11:0]}, 32'h000F);
    do_cmd(OP_INC, 4'd0, 4'd0, 4'd0, 1, 4'd0, 1'b0);
    @(negedge clk);
    check("cnt0_carry", {20'd0, cnt_flat[11:0]}, 32'h0010);

    @(posedge clk);
    #1 inc_req[0] = 1'b1;
    repeat (34) @(posedge clk);
    #1 inc_req[0] = 1'b0;
    @(negedge clk);
    check("cnt0_burst", {20'd0, cnt_flat[11:0]}, 32'h0032);

    // Stream counter 0 (0x032) with a toggling consumer while it keeps counting.
    beat_q.push_back({1'b0, 4'h2});
    beat_q.push_back({1'b0, 4'h3});
    beat_q.push_back({1'b1, 4'h0});
    do_cmd(OP_READ, 4'd0, 4'd0, 4'd0, 1, 4'd0, 1'b0);
    inc_req[0]   = 1'b1;
    bus.rd_ready = 1'b1;
    incs = 0;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (bus.rd_valid) check("cmd_ready_in_read", {31'd0, bus.cmd_ready}, 32'd0);
      if (bus.rd_valid && bus.rd_ready && bus.rd_last) done = 1'b1;
      @(posedge clk);
      incs++;
      #1 bus.rd_ready = ~bus.rd_ready;
    end
    inc_req[0]   = 1'b0;
    bus.rd_ready = 1'b0;
    check("read_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("cmd_ready_after_read", {31'd0, bus.cmd_ready}, 32'd1);
    check("rd_valid_after_read", {31'd0, bus.rd_valid}, 32'd0);
    check("cnt0_after_read", {20'd0, cnt_flat[11:0]}, (32'h032 + incs) & 32'hFFF);

    // FREE and an increment on the same counter in the same cycle.
    prev_ovf   = ovf0_cnt;
    inc_req[0] = 1'b1;
    do_cmd(OP_FREE, 4'd0, 4'd0, 4'd0, 1, 4'd0, 1'b0);
    @(posedge clk);
    #1 inc_req[0] = 1'b0;
    @(negedge clk);
    check("cnt0_after_free_inc", {20'd0, cnt_flat[11:0]}, 32'h0000);
    check("ovf_after_free_inc", ovf0_cnt, prev_ovf);
    do_cmd(OP_ALLOC, 4'd0, 4'd3, 4'd0, 1, 4'd0, 1'b0);

    // Reset while a read is stalled.
    do_cmd(OP_READ, 4'd3, 4'd0, 4'd0, 1, 4'd3, 1'b0);
    repeat (2) @(negedge clk);
    check("rd_valid_stalled", {31'd0, bus.rd_valid}, 32'd1);
    check("rd_data_stalled", {28'd0, bus.rd_data}, 32'd7);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rd_valid_after_rst", {31'd0, bus.rd_valid}, 32'd0);
    check("cmd_ready_after_rst", {31'd0, bus.cmd_ready}, 32'd1);
    check("cnt_lo_after_rst", cnt_flat[31:0], 32'd0);

    do_cmd(OP_ALLOC, 4'd0, 4'd0,  4'd0, 1, 4'd0, 1'b1);
    do_cmd(OP_ALLOC, 4'd0, 4'd11, 4'd0, 1, 4'd0, 1'b1);
    do_cmd(OP_ALLOC, 4'd0, 4'd10, 4'd0, 1, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("rsp_queue_drained", rsp_q.size(), 0);
    check("beat_queue_drained", beat_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
